// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared instruction-field positions, encodings and fetch FSM states
package mips_pkg;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SH_MSB    = 10;
  localparam int SH_LSB    = 6;
  localparam int FN_MSB    = 5;
  localparam int FN_LSB    = 0;
  localparam int JIDX_MSB  = 25;
  localparam int IMM_MSB   = 15;
  localparam int J26_BIT   = 26;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory read bus between fetch unit and imem
interface if_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - redirect target priority mux (JR > Jump > Branch) and PC+4 adder
module pc_next_sel (
  input  logic [31:0] pc_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_plus4_o,
  output logic        redir_o,
  output logic [31:0] target_o
);

  assign pc_plus4_o = pc_i + 32'd4;
  assign redir_o    = jr_i | jump_i | branch_i;

  always_comb begin
    target_o = branch_target_i;
    if (jr_i) begin
      target_o = jr_target_i;
    end else if (jump_i) begin
      // Jump region comes from the sequential PC, not from the jump itself.
      target_o = {pc_plus4_o[31:28], jump_target_i, 2'b00};
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, field slicing, flush/halt control
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               JR,
  input  logic [31:0]        JR_target,
  input  logic               Jump,
  input  logic [25:0]        Jump_target,
  input  logic               Branch,
  input  logic [31:0]        Branch_target,
  if_fetch_unit_if.master    imem,
  output logic [31:0]        PCaddout,
  output logic [5:0]         ins31_26out,
  output logic [5:0]         ins5_0out,
  output logic [4:0]         ins25_21out,
  output logic [4:0]         ins20_16out,
  output logic [4:0]         ins15_11out,
  output logic [4:0]         ins10_6out,
  output logic [25:0]        ins25_0out,
  output logic [15:0]        ins15_0out,
  output logic               ins_26out,
  output logic               flush,
  output logic               halted
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [31:0]  pc_q, pc_d;
  logic [1:0]   cnt_q, cnt_d;
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_plus4, target, word;
  logic         redir;

  pc_next_sel u_pc_next_sel (
    .pc_i            (pc_q),
    .jr_i            (JR),
    .jr_target_i     (JR_target),
    .jump_i          (Jump),
    .jump_target_i   (Jump_target),
    .branch_i        (Branch),
    .branch_target_i (Branch_target),
    .pc_plus4_o      (pc_plus4),
    .redir_o         (redir),
    .target_o        (target)
  );

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redir) begin
      pc_d = target;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          // The halt word itself is not consumed: PC stays on it.
          if (PCWrite) begin
            if (imem.imem_data == HALT_WORD) state_d = ST_HALT;
            else                             pc_d    = pc_plus4;
          end
        end
        ST_FLUSH: begin
          if (PCWrite) pc_d = pc_plus4;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_HALT: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted         = (state_q == ST_HALT);
  assign flush          = redir | (state_q == ST_FLUSH);
  assign imem.imem_addr = pc_q;
  assign word           = halted ? NOP_WORD : imem.imem_data;
  assign PCaddout       = halted ? 32'd0 : pc_plus4;

  assign ins31_26out = word[OP_MSB:OP_LSB];
  assign ins25_21out = word[RS_MSB:RS_LSB];
  assign ins20_16out = word[RT_MSB:RT_LSB];
  assign ins15_11out = word[RD_MSB:RD_LSB];
  assign ins10_6out  = word[SH_MSB:SH_LSB];
  assign ins5_0out   = word[FN_MSB:FN_LSB];
  assign ins25_0out  = word[JIDX_MSB:0];
  assign ins15_0out  = word[IMM_MSB:0];
  assign ins_26out   = word[J26_BIT];

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, JR, Jump, Branch;
  logic [31:0] JR_target, Branch_target;
  logic [25:0] Jump_target;
  logic [31:0] imem_word;

  logic [31:0] PCaddout, d2_PCaddout;
  logic [5:0]  ins31_26out, ins5_0out, d2_ins31_26out, d2_ins5_0out;
  logic [4:0]  ins25_21out, ins20_16out, ins15_11out, ins10_6out;
  logic [4:0]  d2_ins25_21out, d2_ins20_16out, d2_ins15_11out, d2_ins10_6out;
  logic [25:0] ins25_0out, d2_ins25_0out;
  logic [15:0] ins15_0out, d2_ins15_0out;
  logic        ins_26out, flush, halted, d2_ins_26out, d2_flush, d2_halted;

  int tests_run = 0;
  int tests_failed = 0;

  if_fetch_unit_if bus1 ();
  if_fetch_unit_if bus2 ();
  assign bus1.imem_data = imem_word;
  assign bus2.imem_data = imem_word;

  always #5 clk = ~clk;

  if_fetch_unit u_dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite),
    .JR(JR), .JR_target(JR_target), .Jump(Jump), .Jump_target(Jump_target),
    .Branch(Branch), .Branch_target(Branch_target), .imem(bus1),
    .PCaddout(PCaddout), .ins31_26out(ins31_26out), .ins5_0out(ins5_0out),
    .ins25_21out(ins25_21out), .ins20_16out(ins20_16out), .ins15_11out(ins15_11out),
    .ins10_6out(ins10_6out), .ins25_0out(ins25_0out), .ins15_0out(ins15_0out),
    .ins_26out(ins_26out), .flush(flush), .halted(halted)
  );

  if_fetch_unit #(.FLUSH_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .PCWrite(PCWrite),
    .JR(JR), .JR_target(JR_target), .Jump(Jump), .Jump_target(Jump_target),
    .Branch(Branch), .Branch_target(Branch_target), .imem(bus2),
    .PCaddout(d2_PCaddout), .ins31_26out(d2_ins31_26out), .ins5_0out(d2_ins5_0out),
    .ins25_21out(d2_ins25_21out), .ins20_16out(d2_ins20_16out), .ins15_11out(d2_ins15_11out),
    .ins10_6out(d2_ins10_6out), .ins25_0out(d2_ins25_0out), .ins15_0out(d2_ins15_0out),
    .ins_26out(d2_ins_26out), .flush(d2_flush), .halted(d2_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; PCWrite = 1'b0; JR = 1'b0; Jump = 1'b0; Branch = 1'b0;
    JR_target = '0; Jump_target = '0; Branch_target = '0;
    imem_word = 32'h012A_4020;
    #1;
    check("rst_addr",    bus1.imem_addr, 32'h0);
    check("rst_pcadd",   PCaddout, 32'h4);
    check("rst_flush",   {31'b0, flush}, 32'h0);
    check("rst_halted",  {31'b0, halted}, 32'h0);
    check("rst_rs",      {27'b0, ins25_21out}, 32'd9);

    step();
    rst = 1'b1;
    PCWrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("seq_addr",  bus1.imem_addr, 32'(4 * k));
      check("seq_pcadd", PCaddout, 32'(4 * k + 4));
      check("seq_rs",    {27'b0, ins25_21out}, 32'd9);
      check("seq_rt",    {27'b0, ins20_16out}, 32'd10);
      check("seq_rd",    {27'b0, ins15_11out}, 32'd8);
      check("seq_funct", {26'b0, ins5_0out}, 32'h20);
      check("seq_flush", {31'b0, flush}, 32'h0);
      step();
    end
    step();
    PCWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", bus1.imem_addr, 32'h10);
      check("stall_rd",   {27'b0, ins15_11out}, 32'd8);
    end
    PCWrite = 1'b1;
    step();
    check("unstall_addr", bus1.imem_addr, 32'h14);
    step(); step(); step();
    check("pre_redir_addr", bus1.imem_addr, 32'h20);

    PCWrite = 1'b0;
    Branch = 1'b1; Branch_target = 32'h40;
    Jump = 1'b1;   Jump_target = 26'h10;
    #1;
    check("redir_flush", {31'b0, flush}, 32'h1);
    step();
    check("jump_over_branch", bus1.imem_addr, 32'h40);
    JR = 1'b1; JR_target = 32'h80;
    step();
    check("jr_over_all", bus1.imem_addr, 32'h80);
    JR = 1'b0; Jump = 1'b0; Branch = 1'b0; PCWrite = 1'b1;
    #1;
    check("no_redir_flush", {31'b0, flush}, 32'h0);

    rst = 1'b0;
    #1;
    check("d2_rst_addr", bus2.imem_addr, 32'h0);
    rst = 1'b1;
    step(); step();
    check("d2_pc8", bus2.imem_addr, 32'h8);
    Branch = 1'b1; Branch_target = 32'h60;
    #1;
    check("d2_fl_c0", {31'b0, d2_flush}, 32'h1);
    step();
    Branch = 1'b0;
    #1;
    check("d2_fl_c1",   {31'b0, d2_flush}, 32'h1);
    check("d2_br_addr", bus2.imem_addr, 32'h60);
    check("d1_fl_c1",   {31'b0, flush}, 32'h0);
    step();
    check("d2_fl_c2",   {31'b0, d2_flush}, 32'h0);
    check("d2_adv",     bus2.imem_addr, 32'h64);
    Branch = 1'b1; Branch_target = 32'h80;
    #1;
    check("d2_fl2_c0", {31'b0, d2_flush}, 32'h1);
    step();
    Branch_target = 32'h40;
    #1;
    check("d2_fl2_c1", {31'b0, d2_flush}, 32'h1);
    step();
    Branch = 1'b0;
    #1;
    check("d2_fl2_ext",  {31'b0, d2_flush}, 32'h1);
    check("d2_fl2_addr", bus2.imem_addr, 32'h40);
    step();
    check("d2_fl2_end",  {31'b0, d2_flush}, 32'h0);
    check("d2_fl2_adv",  bus2.imem_addr, 32'h44);

    PCWrite = 1'b0;
    Branch = 1'b1; Branch_target = 32'h44;
    step();
    Branch = 1'b0;
    #1;
    check("d2_midflush",      {31'b0, d2_flush}, 32'h1);
    check("d2_midflush_addr", bus2.imem_addr, 32'h44);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_addr",   bus2.imem_addr, 32'h0);
    check("async_rst_flush",  {31'b0, d2_flush}, 32'h0);
    check("async_rst_halted", {31'b0, d2_halted}, 32'h0);
    rst = 1'b1;

    JR = 1'b1; JR_target = 32'h30;
    step();
    JR = 1'b0;
    step();
    check("halt_pre_addr", bus1.imem_addr, 32'h30);
    imem_word = 32'hFFFF_FFFF;
    #1;
    check("halt_stall0", {31'b0, halted}, 32'h0);
    step();
    check("halt_stall1", {31'b0, halted}, 32'h0);
    check("halt_stall_addr", bus1.imem_addr, 32'h30);
    PCWrite = 1'b1;
    step();
    check("halted",        {31'b0, halted}, 32'h1);
    check("halt_addr",     bus1.imem_addr, 32'h30);
    check("halt_pcadd",    PCaddout, 32'h0);
    check("halt_rs",       {27'b0, ins25_21out}, 32'h0);
    check("halt_funct",    {26'b0, ins5_0out}, 32'h0);
    check("halt_jidx",     {6'b0, ins25_0out}, 32'h0);
    check("halt_imm",      {16'b0, ins15_0out}, 32'h0);
    check("halt_b26",      {31'b0, ins_26out}, 32'h0);
    check("halt_flush",    {31'b0, flush}, 32'h0);
    step();
    check("halt_frozen",   bus1.imem_addr, 32'h30);
    JR = 1'b1; JR_target = 32'h100;
    #1;
    check("unhalt_flush",  {31'b0, flush}, 32'h1);
    step();
    JR = 1'b0;
    Branch = 1'b1; Branch_target = 32'h200;
    #1;
    check("unhalt_halted", {31'b0, halted}, 32'h0);
    check("unhalt_addr",   bus1.imem_addr, 32'h100);
    step();
    Branch = 1'b0;
    imem_word = 32'h012A_4020;
    #1;
    check("redir_beats_halt", {31'b0, halted}, 32'h0);
    check("redir_halt_addr",  bus1.imem_addr, 32'h200);

    JR = 1'b1; JR_target = 32'hFFFF_FFFC;
    step();
    JR = 1'b0;
    #1;
    check("wrap_addr",  bus1.imem_addr, 32'hFFFF_FFFC);
    check("wrap_pcadd", PCaddout, 32'h0);
    step();
    check("wrap_next",  bus1.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
